// File: rtl/ten_count_if.sv
// Decade counter handshake bundle: enable in,
// registered count and combinational carry out.
interface ten_count_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [WIDTH-1:0] count;
  logic             co;

  modport master (
    output en,
    input  count,
    input  co
  );

  modport slave (
    input  en,
    output count,
    output co
  );
endinterface

// File: rtl/ten_count.sv
// Mod-MODULUS counter with enable and carry out,
// cascadable by tying the next digit's en to co.
module ten_count #(
  parameter int MODULUS = 10,
  parameter int WIDTH   = 4
) (
  input  logic     clk,
  input  logic     rst,
  ten_count_if.slave bus
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: recover from illegal states, wrap at LAST, else step.
  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      (count_q > LAST):
        count_d = '0;
      (bus.en && (count_q == LAST)):
        count_d = '0;
      (bus.en && (count_q < LAST)):
        count_d = count_q + WIDTH'(1);
      default:
        count_d = count_q;
    endcase
  end

  // Count register, cleared asynchronously by active-low rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.count = count_q;
  assign bus.co    = bus.en & (count_q == LAST);

endmodule

// File: tb/tb_ten_count.sv
// Directed self-checking bench for ten_count,
// including a two-digit cascade.
module tb_ten_count;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ten_count_if #(.WIDTH(4)) if1 ();
  ten_count_if #(.WIDTH(4)) if2 ();

  assign if2.en = if1.co;

  ten_count #(.MODULUS(10), .WIDTH(4)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  ten_count #(.MODULUS(10), .WIDTH(4)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    if1.en = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (if1.count !== 4'd0 || if1.co !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: count=%0d co=%b want 0/0",
                 if1.count, if1.co);
      end
    end
    if1.en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (if1.count !== 4'd0 || if1.co !== 1'b0) begin
        errors++;
        $display("FAIL reset_dom_en: count=%0d co=%b want 0/0",
                 if1.count, if1.co);
      end
    end
  endtask

  task automatic test_full_count();
    int pulses;
    logic [3:0] exp;
    pulses = 0;
    rst    = 1'b1;
    if1.en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp = 4'(i % 10);
      checks++;
      if (if1.count !== exp) begin
        errors++;
        $display("FAIL wrap_count[%0d]: got %0d want %0d",
                 i, if1.count, exp);
      end
      checks++;
      if (if1.co !== (exp == 4'd9)) begin
        errors++;
        $display("FAIL wrap_co[%0d]: got %b want %b",
                 i, if1.co, (exp == 4'd9));
      end
      if (i <= 10 && if1.co === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL co_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_enable_hold();
    if1.en = 1'b1;
    step();
    step();
    checks++;
    if (if1.count !== 4'd4) begin
      errors++;
      $display("FAIL hold_setup: got %0d want 4", if1.count);
    end
    if1.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if1.count !== 4'd4 || if1.co !== 1'b0) begin
        errors++;
        $display("FAIL hold: count=%0d co=%b want 4/0",
                 if1.count, if1.co);
      end
    end
    if1.en = 1'b1;
    step();
    checks++;
    if (if1.count !== 4'd5) begin
      errors++;
      $display("FAIL hold_resume: got %0d want 5", if1.count);
    end
  endtask

  task automatic test_terminal_no_en();
    for (int i = 0; i < 4; i++) step();
    if1.en = 1'b0;
    #1;
    checks++;
    if (if1.count !== 4'd9 || if1.co !== 1'b0) begin
      errors++;
      $display("FAIL term_no_en: count=%0d co=%b want 9/0",
               if1.count, if1.co);
    end
    step();
    checks++;
    if (if1.count !== 4'd9) begin
      errors++;
      $display("FAIL term_hold: got %0d want 9", if1.count);
    end
    if1.en = 1'b1;
    #1;
    checks++;
    if (if1.co !== 1'b1) begin
      errors++;
      $display("FAIL term_co: got %b want 1", if1.co);
    end
    step();
    checks++;
    if (if1.count !== 4'd0 || if1.co !== 1'b0) begin
      errors++;
      $display("FAIL term_wrap: count=%0d co=%b want 0/0",
               if1.count, if1.co);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (if1.count !== 4'd6) begin
      errors++;
      $display("FAIL async_setup: got %0d want 6", if1.count);
    end
    #5;
    rst = 1'b0;
    #1;
    checks++;
    if (if1.count !== 4'd0 || clk !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: count=%0d clk=%b want 0/0",
               if1.count, clk);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_cascade();
    logic [3:0] eu;
    logic [3:0] et;
    logic [3:0] prev_t;
    rst    = 1'b0;
    if1.en = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    if1.en = 1'b1;
    prev_t = 4'd0;
    for (int i = 1; i <= 25; i++) begin
      step();
      eu = 4'(i % 10);
      et = 4'(i / 10);
      checks++;
      if (if1.count !== eu || if2.count !== et) begin
        errors++;
        $display("FAIL cascade[%0d]: got %0d%0d want %0d%0d",
                 i, if2.count, if1.count, et, eu);
      end
      checks++;
      if ((if2.count !== prev_t) !== (if1.count === 4'd0)) begin
        errors++;
        $display("FAIL cascade_edge[%0d]: tens %0d->%0d units %0d",
                 i, prev_t, if2.count, if1.count);
      end
      prev_t = if2.count;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    if1.en = 1'b0;
    test_reset();
    test_full_count();
    test_enable_hold();
    test_terminal_no_en();
    test_async_reset();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ten_count.md
Name: ten_count

Overview:
- Synchronous decade (mod-10) counter with count enable and carry-out, for cascading into multi-digit BCD counters.
- Each enabled clock advances the 4-bit count 0→9 and wraps to 0.
- `co` flags the wrap so the next digit's `en` can be driven directly from it.

Parameters:
- MODULUS, 10, number of states; count runs 0..MODULUS-1. Legal range 2..2^WIDTH.
- WIDTH, 4, width of `count`; must satisfy 2^WIDTH ≥ MODULUS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 clears the counter immediately, independent of clk.
- en  input  1  count enable, active-high, sampled on rising clk edge.
- count  output  WIDTH  current count value, registered.
- co  output  1  carry-out, combinational: high when en=1 and count=MODULUS-1.

Behaviour:
- Reset:
  - rst=0 forces count=0 asynchronously, without waiting for a clock edge.
  - While rst=0, count holds 0 and co=0 (co=0 because count≠MODULUS-1).
  - Reset release (rst 0→1) takes effect at the next rising clk edge. No extra latency cycles.
- Normal operation (rst=1), on each rising clk edge:
  - en=0: count holds.
  - en=1 and count<MODULUS-1: count ← count+1.
  - en=1 and count=MODULUS-1: count ← 0 (wrap).
- Illegal state: count ≥ MODULUS (only reachable via upset or a non-power-of-two WIDTH mismatch) loads 0 on the next edge, regardless of en.
- Carry-out:
  - co = en & (count==MODULUS-1).
  - Purely combinational, so co is valid in the same cycle as the terminal count.
  - Exactly one co-high cycle per MODULUS enabled cycles when en is held high.
  - co=0 whenever en=0, even at count=MODULUS-1.
- Latency: count changes one clock edge after an enabled edge. en has zero-cycle effect on co.
- Cascading:
  - Tie the next stage's en to this stage's co; both stages share clk and rst.
  - The upper digit increments on the same edge the lower digit wraps 9→0.
- Simultaneous events:
  - Asynchronous reset dominates en and the clock edge.
  - rst deassertion coinciding with a clk edge: that edge may or may not count. The bench must not depend on it; it changes en/rst away from clk edges.
- No other state; no outputs other than count and co.

Test Plan:
- Reset from power-up: rst=0, en=0, clk running 20 ns period for 100 ns → count=0, co=0 throughout.
- Reset dominates en: rst=0 with en=1 for 5 clocks → count stays 0. rst pulsed low mid-count (count=6) between clock edges → count=0 immediately, before the next edge.
- Full count with wrap: rst=1, en=1 for 12 rising edges → count 1,2,...,9,0,1,2. co=1 only while count=9. Exactly one co pulse in the 10 edges following count=0.
- Enable hold: with count=4, drop en for 3 edges → count stays 4, co=0. Re-raise en → count 5 on the next edge.
- Terminal count without enable: count=9, en=0 → co=0, count holds 9. Raise en → co=1 immediately, count 0 on the next edge.
- Two-stage cascade: stage2.en=stage1.co, en=1 for 25 edges → (tens, units) reaches (2,5). Tens increments on exactly the edges where units goes 9→0.
